// File: rtl/bcd_cascade_pkg.sv
// Shared states and BCD limits for the cascaded decade counter.
// Optional down-counting is enabled by BCD_CASCADE_CTRL_DOWN_EN.
package bcd_cascade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_cascade_ctrl_digit.sv
// One decade (0-9) stage with clear, saturating load and carry term.
// The dn port exists only when BCD_CASCADE_CTRL_DOWN_EN is defined.
module bcd_digit
    import bcd_cascade_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
`ifdef BCD_CASCADE_CTRL_DOWN_EN
    input  logic       dn,
`endif
    output logic [3:0] q,
    output logic       term
);

    logic [3:0] r_q;
    logic       w_dn;

`ifdef BCD_CASCADE_CTRL_DOWN_EN
    assign w_dn = dn;
`else
    assign w_dn = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= BCD_MIN;
        end else if (clr) begin
            r_q <= BCD_MIN;
        end else if (ld) begin
            r_q <= bcd_sat(ld_val);
        end else if (en) begin
            if (w_dn)
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            else
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
        end
    end

    assign q    = r_q;
    assign term = w_dn ? (r_q == BCD_MIN) : (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_cascade_ctrl.sv
// Multi-digit BCD counter controller: FSM, carry chain, rollover.
// Define BCD_CASCADE_CTRL_DOWN_EN to add the down port.
module bcd_cascade_ctrl
    import bcd_cascade_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int N      = 4,
    parameter int WRAP   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              load,
    input  logic [DIGITS*N-1:0] load_val,
    input  logic              tick,
`ifdef BCD_CASCADE_CTRL_DOWN_EN
    input  logic              down,
`endif
    output logic [DIGITS*N-1:0] count,
    output logic [1:0]        state,
    output logic              running,
    output logic              rollover
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rollover;
    logic                w_inc;
    logic                w_evt;
    logic                w_hold;
    logic [DIGITS-1:0]   w_term;
    logic [DIGITS-1:0]   w_en;
    logic [DIGITS:0]     w_chain;

    // Any higher-priority control in the same cycle swallows the tick.
    assign w_inc  = (r_state == ST_RUN) & tick & ~clear & ~load & ~stop;
    assign w_evt  = w_inc & w_chain[DIGITS];
    assign w_hold = w_evt & (WRAP == 0);

    assign w_chain[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign w_chain[k+1] = w_chain[k] & w_term[k];
        assign w_en[k]      = w_inc & w_chain[k] & ~w_hold;

        bcd_digit u_dig (
            .clk    (clk),
            .reset  (reset),
            .en     (w_en[k]),
            .clr    (clear),
            .ld     (load),
            .ld_val (load_val[k*N +: N]),
`ifdef BCD_CASCADE_CTRL_DOWN_EN
            .dn     (down),
`endif
            .q      (count[k*N +: N]),
            .term   (w_term[k])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (load) begin
            if (r_state == ST_HALT)
                w_state_nxt = ST_PAUSE;
        end else if (stop) begin
            if (r_state == ST_RUN)
                w_state_nxt = ST_PAUSE;
        end else if (start &&
                     (r_state == ST_IDLE || r_state == ST_PAUSE)) begin
            w_state_nxt = ST_RUN;
        end else if (w_hold) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rollover <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rollover <= w_evt;
        end
    end

    assign state    = r_state;
    assign running  = (r_state == ST_RUN);
    assign rollover = r_rollover;

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Bench: two DUTs (4 digits wrapping, 2 digits halting) on shared
// stimulus, checked every cycle against an integer-valued model.
module tb_bcd_cascade_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        tick = 1'b0;
    logic        down = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] a_count;
    logic [1:0]  a_state;
    logic        a_running, a_ro;
    logic [7:0]  b_count;
    logic [1:0]  b_state;
    logic        b_running, b_ro;

    always #5 clk = ~clk;

    bcd_cascade_ctrl #(.DIGITS(4), .N(4), .WRAP(1)) u_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
`ifdef BCD_CASCADE_CTRL_DOWN_EN
        .down     (down),
`endif
        .count    (a_count),
        .state    (a_state),
        .running  (a_running),
        .rollover (a_ro)
    );

    bcd_cascade_ctrl #(.DIGITS(2), .N(4), .WRAP(0)) u_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val[7:0]),
        .tick     (tick),
`ifdef BCD_CASCADE_CTRL_DOWN_EN
        .down     (down),
`endif
        .count    (b_count),
        .state    (b_state),
        .running  (b_running),
        .rollover (b_ro)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int mv  [2];
    int mst [2];
    bit mro [2];

    function automatic int pow10(int d);
        int p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    function automatic int ld_dec(logic [15:0] lv, int d);
        int v = 0;
        for (int k = 0; k < d; k++) begin
            int dig = int'((lv >> (4 * k)) & 16'hF);
            if (dig > 9) dig = 9;
            v = v + dig * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(int v, int d);
        logic [31:0] r = '0;
        for (int k = 0; k < d; k++) begin
            r = r | (32'(v % 10) << (4 * k));
            v = v / 10;
        end
        return r;
    endfunction

    // States: 0 idle, 1 run, 2 pause, 3 halt.
    task automatic mstep(int i, int d, bit wrap);
        int maxv = pow10(d) - 1;
        bit dn = 1'b0;
`ifdef BCD_CASCADE_CTRL_DOWN_EN
        dn = down;
`endif
        mro[i] = 1'b0;
        if (!reset) begin
            mv[i] = 0; mst[i] = 0;
        end else if (clear) begin
            mv[i] = 0; mst[i] = 0;
        end else if (load) begin
            mv[i] = ld_dec(load_val, d);
            if (mst[i] == 3) mst[i] = 2;
        end else if (stop) begin
            if (mst[i] == 1) mst[i] = 2;
        end else if (start && (mst[i] == 0 || mst[i] == 2)) begin
            mst[i] = 1;
        end else if (mst[i] == 1 && tick) begin
            if (!dn) begin
                if (mv[i] == maxv) begin
                    mro[i] = 1'b1;
                    if (wrap) mv[i] = 0; else mst[i] = 3;
                end else mv[i] = mv[i] + 1;
            end else begin
                if (mv[i] == 0) begin
                    mro[i] = 1'b1;
                    if (wrap) mv[i] = maxv; else mst[i] = 3;
                end else mv[i] = mv[i] - 1;
            end
        end
    endtask

    always @(posedge clk) begin
        mstep(0, 4, 1'b1);
        mstep(1, 2, 1'b0);
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a.count", 32'(a_count), to_bcd(mv[0], 4));
            cmp("a.state", 32'(a_state), 32'(mst[0]));
            cmp("a.running", 32'(a_running), 32'(mst[0] == 1));
            cmp("a.rollover", 32'(a_ro), 32'(mro[0]));
            cmp("b.count", 32'(b_count), to_bcd(mv[1], 2));
            cmp("b.state", 32'(b_state), 32'(mst[1]));
            cmp("b.running", 32'(b_running), 32'(mst[1] == 1));
            cmp("b.rollover", 32'(b_ro), 32'(mro[1]));
        end
    end

    task automatic step(bit rs = 1, bit st = 0, bit sp = 0, bit cl = 0,
                        bit ld = 0, bit tk = 0, logic [15:0] lv = '0);
        reset = rs; start = st; stop = sp; clear = cl;
        load = ld; tick = tk; load_val = lv;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        step(.rs(0));
        chk_en = 1'b1;
        step(.rs(0), .st(1), .tk(1));
        cmp("lit.reset.count", 32'(a_count), 32'h0);
        cmp("lit.reset.state", 32'(a_state), 32'h0);

        step(.st(1), .tk(1));
        repeat (12) step(.st(1), .tk(1));
        cmp("lit.12ticks.b", 32'(b_count), 32'h12);
        cmp("lit.12ticks.a", 32'(a_count), 32'h0012);
        cmp("lit.12ticks.state", 32'(a_state), 32'h1);

        step(.ld(1), .lv(16'h0098));
        step(.tk(1));
        cmp("lit.carry1.a", 32'(a_count), 32'h0099);
        step(.tk(1));
        cmp("lit.carry2.a", 32'(a_count), 32'h0100);
        cmp("lit.halt.b.count", 32'(b_count), 32'h99);
        cmp("lit.halt.b.state", 32'(b_state), 32'h3);
        cmp("lit.halt.b.ro", 32'(b_ro), 32'h1);
        repeat (3) step(.st(1), .tk(1));
        cmp("lit.halt.start_ign", 32'(b_state), 32'h3);
        cmp("lit.halt.ro_once", 32'(b_ro), 32'h0);
        step(.cl(1), .tk(1));
        cmp("lit.clear.b", 32'(b_count), 32'h0);
        cmp("lit.clear.bstate", 32'(b_state), 32'h0);

        step(.ld(1), .lv(16'h9999));
        step(.st(1), .tk(1));
        step(.tk(1));
        cmp("lit.wrap.a", 32'(a_count), 32'h0000);
        cmp("lit.wrap.ro", 32'(a_ro), 32'h1);
        cmp("lit.wrap.state", 32'(a_state), 32'h1);
        step();
        cmp("lit.wrap.ro_drop", 32'(a_ro), 32'h0);

        step(.st(1));
        step(.cl(1), .ld(1), .tk(1), .lv(16'h1234));
        cmp("lit.prio.count", 32'(a_count), 32'h0);
        cmp("lit.prio.state", 32'(a_state), 32'h0);
        step(.st(1));
        step(.st(1), .sp(1), .tk(1));
        cmp("lit.startstop", 32'(a_state), 32'h2);

        step(.ld(1), .lv(16'hFA3C));
        cmp("lit.sat.a", 32'(a_count), 32'h9939);
        cmp("lit.sat.b", 32'(b_count), 32'h39);

        step(.st(1));
        step(.tk(1));
        step(.rs(0), .st(1), .tk(1));
        cmp("lit.midreset.count", 32'(a_count), 32'h0);
        cmp("lit.midreset.state", 32'(a_state), 32'h0);

`ifdef BCD_CASCADE_CTRL_DOWN_EN
        down = 1'b1;
        step(.ld(1), .lv(16'h0100));
        step(.st(1), .tk(1));
        step(.tk(1));
        cmp("lit.down.a", 32'(a_count), 32'h0099);
        step(.ld(1), .lv(16'h0000));
        step(.tk(1));
        cmp("lit.down.wrap", 32'(a_count), 32'h9999);
        cmp("lit.down.ro", 32'(a_ro), 32'h1);
        down = 1'b0;
`endif

        repeat (4000) begin
            logic [15:0] lv;
            case ($urandom_range(0, 4))
                0: lv = 16'h9998;
                1: lv = 16'h0001;
                2: lv = 16'h9999;
                3: lv = 16'h0000;
                default: lv = 16'($urandom);
            endcase
            if ($urandom_range(0, 31) == 0) down = ~down;
            step(.rs($urandom_range(0, 199) != 0),
                 .st($urandom_range(0, 4) == 0),
                 .sp($urandom_range(0, 15) == 0),
                 .cl($urandom_range(0, 39) == 0),
                 .ld($urandom_range(0, 19) == 0),
                 .tk($urandom_range(0, 9) < 7),
                 .lv(lv));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_ctrl.md
Name: bcd_cascade_ctrl

Overview:
- Sequencing controller for a chain of DIGITS decade (0-9) counter stages, forming a multi-digit BCD counter with start/stop/clear/load control.
- Gates the per-digit increment enables, handles digit-to-digit carry, and reports rollover or terminal count.
- Sits between user/timebase control logic and the display or compare logic consuming the BCD value.

Parameters:
- DIGITS, 4, number of cascaded decade stages (1-8).
- N, 4, bits per digit; fixed BCD, must be 4.
- WRAP, 1, 1 = wrap from all-9s to all-0s; 0 = halt at all-9s.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset (asserted when 0, sampled on the clk rising edge).
- start  in  1  level; begin or resume counting.
- stop  in  1  level; pause counting.
- clear  in  1  pulse; zero all digits.
- load  in  1  pulse; load load_val.
- load_val  in  DIGITS*N  BCD preset, digit 0 in bits [3:0].
- tick  in  1  count-enable strobe from the timebase; one increment per cycle in which tick=1.
- count  out  DIGITS*N  registered BCD value, digit 0 least significant.
- state  out  2  FSM state encoding.
- running  out  1  1 when state=RUN.
- rollover  out  1  one-cycle pulse on wrap or on reaching terminal count.

Behaviour:
- Reset (reset=0 at a clk edge): count=0, state=IDLE, running=0, rollover=0. Reset overrides all other inputs.
- States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, HALT=2'b11.
- Control priority per cycle: clear > load > stop > start > tick.
- clear:
  - count=0 next cycle.
  - state→IDLE from any state; the tick in the same cycle is ignored.
- load:
  - count=load_val next cycle; state unchanged, except HALT→PAUSE.
  - Any digit of load_val >9 is saturated to 9 on load.
- stop: RUN→PAUSE; other states hold.
- start: IDLE/PAUSE→RUN. Ignored in HALT; only clear or load exits HALT.
- start and stop both high: stop wins.
- Increment:
  - Only in RUN with tick=1.
  - Digit k increments when tick=1 and digits 0..k-1 all equal 9.
  - A digit at 9 that increments becomes 0.
  - Latency: count updates on the edge following the tick cycle.
- Terminal count: the value is all 9s and an increment occurs.
  - WRAP=1: count→0, rollover=1 for one cycle, state stays RUN.
  - WRAP=0: count holds all 9s, rollover=1 for one cycle, state→HALT.
- A tick in the same cycle as a start from IDLE/PAUSE is not counted; counting begins with the next tick.
- rollover is registered and is 0 in every cycle without a terminal event.
- Reset mid-count: the next edge gives count=0 and IDLE, regardless of tick or other controls.

Optional Feature:
- Macro: BCD_CASCADE_CTRL_DOWN_EN.
- Defined:
  - Adds input port `down` (1 bit).
  - When down=1, the increment rule becomes decrement: digit k decrements when digits 0..k-1 are all 0, and 0→9.
  - Terminal value for down-counting is all 0s. WRAP=1 wraps to all 9s; WRAP=0 halts in HALT at all 0s.
  - rollover pulses as for up-counting.
  - Changing `down` mid-RUN takes effect on the next tick.
- Undefined: no `down` port; up-count only.

Decomposition:
- Package bcd_cascade_pkg:
  - state typedef/localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_HALT.
  - BCD_MAX=4'd9, BCD_MIN=4'd0.
- Sub-module bcd_digit: one 4-bit decade stage.
  - Inputs: clk, reset, en, clr, ld, ld_val, (dn).
  - Outputs: q, and term (q==9, or q==0 when counting down).
- Instantiate DIGITS copies via generate. The controller builds the en chain from the AND of the lower-digit term outputs and owns the FSM and rollover.

Test Plan:
- Reset, then start=1 and 12 ticks with DIGITS=2 → count=0x12, state=RUN, rollover never asserted.
- load 0x0098, start, 2 ticks → count 0x0099 then 0x0100; digit-1 and digit-2 carry correct.
- WRAP=1, DIGITS=2, load 0x99, start, 1 tick → count=0x00, rollover high exactly one cycle, state=RUN.
- WRAP=0, load all 9s, start, 3 ticks → count stays all 9s, rollover one pulse, state=HALT; start ignored; clear → 0 and IDLE.
- Priority checks:
  - clear+load+tick in one cycle → count=0, IDLE.
  - start+stop → PAUSE.
  - reset=0 mid-run with tick=1 → count=0, IDLE next edge.
- With BCD_CASCADE_CTRL_DOWN_EN: load 0x0100, down=1, start, 1 tick → 0x0099; from 0x00 with WRAP=1 → 0x99 plus rollover pulse.
